// File: rtl/cnt8_dn.sv
// rtl/cnt8_dn.sv - cascadable down counter with load, auto-reload and one-shot halt
//
// Ports:
//   clk  in        sole clock, rising edge
//   rst  in        asynchronous active-low reset
//   ld   in        synchronous load strobe (q and reload value <= d, state <= RUN)
//   d    in  [W]   load value
//   bi   in        borrow-in / count enable (cascade from previous stage's bo)
//   arl  in        auto-reload from the reload value at underflow
//   os   in        one-shot: halt at underflow (wins over arl)
//   bo   out       borrow-out, combinational
//   q    out [W]   current count, registered
//   hlt  out       high while halted, registered
module cnt8_dn #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] d,
    input  logic         bi,
    input  logic         arl,
    input  logic         os,
    output logic         bo,
    output logic [W-1:0] q,
    output logic         hlt
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t       r_state;
    logic [W-1:0] r_q;
    logic [W-1:0] r_rv;
    logic         r_hlt;
    logic         w_zero;

    assign w_zero = (r_q == '0);

    // Borrow-out deliberately ignores ld so a cascaded upper stage sees the
    // borrow of this cycle even when this stage is being reloaded.
    assign bo  = bi & w_zero & (r_state == S_RUN);
    assign q   = r_q;
    assign hlt = r_hlt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RUN;
            r_q     <= '0;
            r_rv    <= '0;
            r_hlt   <= 1'b0;
        end else if (ld) begin
            r_state <= S_RUN;
            r_q     <= d;
            r_rv    <= d;
            r_hlt   <= 1'b0;
        end else if (r_state == S_RUN && bi) begin
            if (!w_zero) begin
                r_q <= r_q - 1'b1;
            end else if (os) begin
                // q is already zero; halting just freezes it there.
                r_state <= S_HALT;
                r_hlt   <= 1'b1;
            end else if (arl) begin
                r_q <= r_rv;
            end else begin
                r_q <= '1;
            end
        end
    end

endmodule

// File: tb/tb_cnt8_dn.sv
// tb/tb_cnt8_dn.sv - table-driven self-checking bench for cnt8_dn
module tb_cnt8_dn;

    logic       clk;
    logic       rst;
    logic       ld;
    logic [7:0] d;
    logic       bi;
    logic       arl;
    logic       os;
    logic       bo;
    logic [7:0] q;
    logic       hlt;

    logic       rst2;
    logic       bi_lo;
    logic       bo_lo;
    logic       bo_hi;
    logic [7:0] q_lo;
    logic [7:0] q_hi;
    logic       hlt_lo;
    logic       hlt_hi;

    int n_checks = 0;
    int n_fail   = 0;

    cnt8_dn #(.W(8)) u_dut (
        .clk(clk), .rst(rst), .ld(ld), .d(d), .bi(bi), .arl(arl), .os(os),
        .bo(bo), .q(q), .hlt(hlt)
    );

    cnt8_dn #(.W(8)) u_lo (
        .clk(clk), .rst(rst2), .ld(1'b0), .d(8'h00), .bi(bi_lo), .arl(1'b0), .os(1'b0),
        .bo(bo_lo), .q(q_lo), .hlt(hlt_lo)
    );

    cnt8_dn #(.W(8)) u_hi (
        .clk(clk), .rst(rst2), .ld(1'b0), .d(8'h00), .bi(bo_lo), .arl(1'b0), .os(1'b0),
        .bo(bo_hi), .q(q_hi), .hlt(hlt_hi)
    );

    // No clock edge until 25 ns so the async reset at 5 ns is seen clockless.
    initial begin
        clk = 1'b0;
        #20;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       ld;
        logic [7:0] d;
        logic       bi;
        logic       arl;
        logic       os;
        logic       pre_bo;
        logic [7:0] q;
        logic       hlt;
        logic       bo;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic ld_i, input logic [7:0] d_i, input logic bi_i,
                                input logic arl_i, input logic os_i, input logic pre_bo_i,
                                input logic [7:0] q_i, input logic hlt_i, input logic bo_i);
        vec_t v;
        v.ld = ld_i; v.d = d_i; v.bi = bi_i; v.arl = arl_i; v.os = os_i;
        v.pre_bo = pre_bo_i; v.q = q_i; v.hlt = hlt_i; v.bo = bo_i;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ld = 1'b0; d = 8'h00; bi = 1'b1; arl = 1'b0; os = 1'b0;
        rst2 = 1'b0; bi_lo = 1'b0;

        //          ld  d      bi  arl os  preBo q      hlt bo
        // free-running wrap after reset
        vt.push_back(mk(0, 8'h00, 1, 0, 0, 1, 8'hFF, 0, 0));
        vt.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'hFE, 0, 0));
        vt.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'hFD, 0, 0));
        // load 3 with auto-reload
        vt.push_back(mk(1, 8'h03, 0, 1, 0, 0, 8'h03, 0, 0));
        vt.push_back(mk(0, 8'h00, 1, 1, 0, 0, 8'h02, 0, 0));
        vt.push_back(mk(0, 8'h00, 1, 1, 0, 0, 8'h01, 0, 0));
        vt.push_back(mk(0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 1));
        vt.push_back(mk(0, 8'h00, 1, 1, 0, 1, 8'h03, 0, 0));
        vt.push_back(mk(0, 8'h00, 1, 1, 0, 0, 8'h02, 0, 0));
        vt.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'h02, 0, 0));
        vt.push_back(mk(0, 8'h00, 1, 1, 0, 0, 8'h01, 0, 0));
        // one-shot: load 2, run down, halt, ignore bi/arl/os while halted
        vt.push_back(mk(1, 8'h02, 1, 0, 1, 0, 8'h02, 0, 0));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h01, 0, 0));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 1));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h00, 1, 0));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 1, 0));
        vt.push_back(mk(0, 8'h00, 1, 1, 0, 0, 8'h00, 1, 0));
        vt.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0));
        vt.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 1, 0));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 1, 0));
        vt.push_back(mk(1, 8'h05, 1, 0, 1, 0, 8'h05, 0, 0));
        // load with bi=1 at q=00: bo still asserts, load wins over wrap
        vt.push_back(mk(1, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0));
        vt.push_back(mk(1, 8'h7A, 1, 0, 0, 1, 8'h7A, 0, 0));
        // load of zero then immediate wrap
        vt.push_back(mk(1, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0));
        vt.push_back(mk(0, 8'h00, 1, 0, 0, 1, 8'hFF, 0, 0));
        // os toggled mid-count has no effect; only its value at underflow matters
        vt.push_back(mk(1, 8'h02, 0, 1, 0, 0, 8'h02, 0, 0));
        vt.push_back(mk(0, 8'h00, 1, 1, 1, 0, 8'h01, 0, 0));
        vt.push_back(mk(0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 1));
        vt.push_back(mk(0, 8'h00, 1, 1, 0, 1, 8'h02, 0, 0));

        // async reset with no clock
        #5 rst = 1'b0;
        #1;
        chk("rst_q", {8'h00, q}, 16'h0000);
        chk("rst_hlt", {15'd0, hlt}, 16'd0);
        chk("rst_bo", {15'd0, bo}, 16'd1);
        #4 rst = 1'b1;

        foreach (vt[i]) begin
            ld = vt[i].ld; d = vt[i].d; bi = vt[i].bi; arl = vt[i].arl; os = vt[i].os;
            #1;
            chk($sformatf("v%0d_pre_bo", i), {15'd0, bo}, {15'd0, vt[i].pre_bo});
            tick();
            chk($sformatf("v%0d_q", i), {8'h00, q}, {8'h00, vt[i].q});
            chk($sformatf("v%0d_hlt", i), {15'd0, hlt}, {15'd0, vt[i].hlt});
            chk($sformatf("v%0d_bo", i), {15'd0, bo}, {15'd0, vt[i].bo});
        end

        // async reset mid-count (q=02), between edges
        ld = 1'b0; bi = 1'b1; arl = 1'b0; os = 1'b0;
        tick();
        chk("mid_q_before", {8'h00, q}, 16'h0001);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_q", {8'h00, q}, 16'h0000);
        chk("mid_rst_bo", {15'd0, bo}, 16'd1);
        // reset dominates ld across an edge
        ld = 1'b1; d = 8'h44;
        tick();
        chk("rst_over_ld_q", {8'h00, q}, 16'h0000);
        rst = 1'b1; ld = 1'b0; bi = 1'b0;

        // reset while halted
        ld = 1'b1; d = 8'h00; os = 1'b1;
        tick();
        ld = 1'b0; bi = 1'b1;
        tick();
        chk("halt_entry_hlt", {15'd0, hlt}, 16'd1);
        #2 rst = 1'b0;
        #1;
        chk("halt_rst_hlt", {15'd0, hlt}, 16'd0);
        chk("halt_rst_bo", {15'd0, bo}, 16'd1);
        #1 rst = 1'b1; os = 1'b0;
        // first edge after release counts (RUN at q=00 wraps)
        tick();
        chk("post_rst_q", {8'h00, q}, 16'h00FF);

        // cascaded 16-bit counter
        bi_lo = 1'b1;
        #1 rst2 = 1'b1;
        tick();
        chk("casc_1", {q_hi, q_lo}, 16'hFFFF);
        for (int k = 0; k < 256; k++) tick();
        chk("casc_257", {q_hi, q_lo}, 16'hFEFF);
        for (int k = 0; k < 3; k++) tick();
        chk("casc_260", {q_hi, q_lo}, 16'hFEFC);
        #2 rst2 = 1'b0;
        #1;
        chk("casc_rst", {q_hi, q_lo}, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cnt8_dn.md
CNT8_DN -- requirements
Module: cnt8_dn

Interface
REQ-001 Parameter W, default 8, counter width in bits; all W-wide ports and registers follow it.
REQ-002 The module SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-004 The module SHALL have port ld, input, 1, synchronous load strobe.
REQ-005 The module SHALL have port d, input, W, load value.
REQ-006 The module SHALL have port bi, input, 1, borrow-in / count enable; cascade from the previous stage's bo.
REQ-007 The module SHALL have port arl, input, 1, auto-reload select at underflow.
REQ-008 The module SHALL have port os, input, 1, one-shot select at underflow; takes precedence over arl.
REQ-009 The module SHALL have port bo, output, 1, borrow-out, combinational.
REQ-010 The module SHALL have port q, output, W, current count, registered.
REQ-011 The module SHALL have port hlt, output, 1, high while in HALT state, registered.

Function
REQ-012 The module SHALL hold internal reload register rv (W bits) and a two-state FSM: RUN, HALT.
REQ-013 The module SHALL drive bo = bi AND (q == 0) AND (state == RUN), independent of ld.
REQ-014 ld=1 at a rising edge SHALL set q<=d, rv<=d and state<=RUN, overriding bi, os, arl and HALT.
REQ-015 RUN, ld=0, bi=0: q, rv and state SHALL hold.
REQ-016 RUN, ld=0, bi=1, q!=0: q SHALL become q-1, with no other change.
REQ-017 RUN, ld=0, bi=1, q==0, os=1: q SHALL stay 0 and state SHALL become HALT.
REQ-018 RUN, ld=0, bi=1, q==0, os=0, arl=1: q SHALL become rv and state SHALL stay RUN.
REQ-019 RUN, ld=0, bi=1, q==0, os=0, arl=0: q SHALL wrap to 2^W-1 (all ones) and state SHALL stay RUN.
REQ-020 HALT, ld=0: q SHALL hold 0, bi SHALL be ignored, and bo SHALL be 0.
REQ-021 hlt SHALL equal 1 exactly while state==HALT; it rises the cycle after the REQ-017 edge and falls the cycle after a load.
REQ-022 Arithmetic SHALL be modulo 2^W with no saturation; rv changes only on load or reset.
REQ-023 A load of d=0 SHALL be legal: the next bi=1 cycle underflows per REQ-017..019.
REQ-024 Cascading SHALL work: stage k+1's bi tied to stage k's bo gives a W*(k+1)-bit down counter when os=0 and arl=0.
REQ-025 os and arl SHALL be sampled only on the underflow edge; changing them mid-count has no other effect.

Reset
REQ-026 rst=0 SHALL immediately, without a clock, force q=0, rv=0, state=RUN and hlt=0; bo then equals bi.
REQ-027 Reset SHALL dominate ld and bi and may assert at any point, including mid-count or in HALT.
REQ-028 Reset release SHALL be synchronous to clk; the first counting edge is the first rising edge with rst=1.

Verification
REQ-029 Async reset at 5 ns, no clock edge -> q=00, hlt=0; with bi=1, bo=1 while q=00.
REQ-030 After reset, os=0, arl=0, bi=1 -> first edge gives q=FF; next edges give FE, FD...; bo=1 only in the q=00 cycle.
REQ-031 ld=1, d=03, arl=1, os=0, then bi=1 for 6 edges -> q=03,02,01,00,03,02; bo high only while q=00.
REQ-032 ld=1, d=02, os=1, bi=1 -> q=02,01,00, then HALT: hlt=1, q stays 00, bo=0 for 5 further edges; then ld=1, d=05 -> q=05, hlt=0.
REQ-033 ld=1 and bi=1 on the same edge with q=00 and d=7A -> q=7A (no wrap), bo=1 during that cycle.
REQ-034 Two instances cascaded (W=8), both reset, bi=1 on the low stage -> after 1 edge {hi,lo}=FFFF, after 257 edges FEFF; rst=0 mid-count clears both to 0000 asynchronously.
